serial_frame_rx: RTL and testbench

Serial frame receiver: samples a one-bit serial line, one bit per clock, and reassembles fixed-width data words. It is the consuming end of the single-bit register pipelines in our example netlists: module outputs such as `out` drive `in` here. Recovered words are presented on a valid/ready output port backed by a one-entry holding buffer, so the block also serves as a sequential sink for path-timing experiments.

---
 rtl/serial_frame_pkg.sv | 22 ++
 rtl/serial_frame_rx_shift_in.sv | 46 ++++
 rtl/serial_frame_rx.sv | 124 ++++++++++++
 tb/tb_serial_frame_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared types and line-level constants for the serial
// frame receiver.
//   rx_state_t  - receiver FSM state. PARITY is always present so the state
//                 encoding is the same whether or not the parity feature
//                 (SERIAL_FRAME_RX_PARITY_EN) is compiled in.
//   START_BIT   - line level that opens a frame.
//   STOP_BIT    - line level required at the end of a good frame.
//   IDLE_LEVEL  - line level between frames.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_rx_shift_in.sv
// serial_shift_in: DATA_W-wide receive register written one bit at a time at
// an explicit bit position, plus a running XOR of every bit taken in.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - frame start: clears data and parity
//   shift_en  - write bit_in at position idx and fold it into parity
//   par_en    - fold bit_in into parity only (parity bit of the frame)
//   bit_in    - sampled serial bit
//   idx       - bit position for the write
//   data      - parallel read of the assembled word
//   par       - running parity of all bits taken in since clr
module serial_shift_in
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              par_en,
  input  logic              bit_in,
  input  logic [CNT_W-1:0]  idx,
  output logic [DATA_W-1:0] data,
  output logic              par
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      par  <= 1'b0;
    end else if (clr) begin
      data <= '0;
      par  <= 1'b0;
    end else begin
      if (shift_en) begin
        data[idx] <= bit_in;
        par       <= par ^ bit_in;
      end
      if (par_en) begin
        par <= par ^ bit_in;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: one-bit-per-clock serial frame receiver with a one-entry
// valid/ready output buffer.
// Frame: start (1), DATA_W data bits LSB first, [even parity], stop (0).
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN adds the parity bit.
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   in         - serial line, idle 0
//   out_data   - received word (only changes on a load)
//   out_valid  - out_data holds an unconsumed word
//   out_ready  - consumer accepts when out_valid && out_ready
//   frame_err  - one-cycle pulse on bad stop bit / bad parity
//   overflow   - one-cycle pulse when a good frame is dropped (buffer full)
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overflow
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              clr;
  logic              shift_en;
  logic              par_en;
  logic              frame_good;
  logic              handshake;

  assign clr       = (state == IDLE) && (in == START_BIT);
  assign shift_en  = (state == DATA);
  assign par_en    = (state == PARITY);
  assign handshake = out_valid && out_ready;
  // par already includes the parity bit when the stop bit is sampled, so an
  // even-parity frame leaves it at 0.
  assign frame_good = (in == STOP_BIT) && (!PAR_EN || !par);

  serial_shift_in #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .par_en   (par_en),
    .bit_in   (in),
    .idx      (cnt),
    .data     (shreg),
    .par      (par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (handshake) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in == START_BIT) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          if (cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          state <= STOP;
        end
        STOP: begin
          // A bad stop bit is never reused as a start bit: always back to IDLE.
          state <= IDLE;
          if (frame_good) begin
            // A same-edge handshake frees the buffer for the new word.
            if (!out_valid || handshake) begin
              out_data  <= shreg;
              out_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;
  import serial_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = IDLE_LEVEL;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overflow;

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (sin),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       e;
    logic       o;
    logic [7:0] d;
  } stat_t;

  stat_t      qstat[$];
  logic [7:0] qword[$];
  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 1;  // 0: never ready, 1: always, 2: random, 3: only on stop bits

  // Reference buffer: one word slot, updated per frame outcome.
  logic       m_v = 1'b0;
  logic [7:0] m_d = 8'h00;

  // Per-edge status monitor (outputs after each edge).
  stat_t mon_s;
  always @(posedge clk) begin
    #1;
    if (qstat.size() > 0) begin
      mon_s = qstat.pop_front();
      vectors++;
      if ({out_valid, frame_err, overflow} !== {mon_s.v, mon_s.e, mon_s.o} ||
          (mon_s.v && out_data !== mon_s.d)) begin
        miscompares++;
        $display("FAIL status @%0t: got v=%b err=%b ovf=%b data=%h, want v=%b err=%b ovf=%b data=%h",
                 $time, out_valid, frame_err, overflow, out_data,
                 mon_s.v, mon_s.e, mon_s.o, mon_s.d);
      end
    end
  end

  // Handshake monitor: a word is consumed at the coming edge.
  logic [7:0] mon_w;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (qword.size() == 0) begin
        miscompares++;
        $display("FAIL word @%0t: got unexpected word %h, want none", $time, out_data);
      end else begin
        mon_w = qword.pop_front();
        if (out_data !== mon_w) begin
          miscompares++;
          $display("FAIL word @%0t: got %h, want %h", $time, out_data, mon_w);
        end
      end
    end
  end

  // evt: 0 = no frame end, 1 = good frame ends, 2 = bad frame ends
  task automatic tick(input logic b, input int evt, input logic [7:0] fd);
    logic  rdy;
    stat_t s;
    @(posedge clk);
    #3;
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = (evt != 0);
    endcase
    sin       = b;
    out_ready = rdy;
    if (m_v && rdy) begin
      qword.push_back(m_d);
      m_v = 1'b0;
    end
    s.e = 1'b0;
    s.o = 1'b0;
    if (evt == 1) begin
      if (!m_v) begin
        m_v = 1'b1;
        m_d = fd;
      end else begin
        s.o = 1'b1;
      end
    end else if (evt == 2) begin
      s.e = 1'b1;
    end
    s.v = m_v;
    s.d = m_d;
    qstat.push_back(s);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(IDLE_LEVEL, 0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    logic good;
    good = (stop == STOP_BIT);
    tick(START_BIT, 0, d);
    for (int i = 0; i < 8; i++) tick(d[i], 0, d);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    tick((^d) ^ pflip, 0, d);
    good = good && !pflip;
`endif
    tick(stop, good ? 1 : 2, d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst       = 1'b1;
    sin       = IDLE_LEVEL;
    out_ready = 1'b0;
    m_v       = 1'b0;
    m_d       = 8'h00;
    #1;
    vectors++;
    if ({out_valid, frame_err, overflow} !== 3'b000 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: got v=%b err=%b ovf=%b data=%h, want all 0",
               out_valid, frame_err, overflow, out_data);
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       rstop;
    logic       rflip;
    do_reset();
    idle(2);

    // Single word, consumer always ready.
    rdy_mode = 1;
    send_frame(8'hA5, STOP_BIT, 1'b0);
    idle(3);

    // Back-to-back with consumer stalled: second frame overflows.
    rdy_mode = 0;
    send_frame(8'h3C, STOP_BIT, 1'b0);
    send_frame(8'hFF, STOP_BIT, 1'b0);
    idle(2);
    rdy_mode = 1;
    idle(3);

    // Bad stop bit, then a good frame two cycles after it.
    send_frame(8'h12, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h34, STOP_BIT, 1'b0);
    idle(3);

    // Handshake on the same edge as a frame completion.
    rdy_mode = 0;
    send_frame(8'h01, STOP_BIT, 1'b0);
    idle(1);
    rdy_mode = 3;
    send_frame(8'h02, STOP_BIT, 1'b0);
    rdy_mode = 1;
    idle(3);

    // Reset mid-frame abandons it.
    tick(START_BIT, 0, 8'h55);
    for (int i = 0; i < 4; i++) tick(i[0], 0, 8'h55);
    do_reset();
    send_frame(8'h0F, STOP_BIT, 1'b0);
    idle(3);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_frame(8'h07, STOP_BIT, 1'b0);
    idle(2);
    send_frame(8'h07, STOP_BIT, 1'b1);
    idle(2);
`endif

    // Randomized frames, errors, gaps and consumer behaviour.
    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(0, 2);
      rd       = 8'($urandom);
      rstop    = ($urandom_range(0, 7) == 0);
      rflip    = ($urandom_range(0, 7) == 0);
      send_frame(rd, rstop, rflip);
      idle($urandom_range(0, 3));
    end
    rdy_mode = 1;
    idle(4);
    @(posedge clk);
    #2;

    vectors++;
    if (qword.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d words never consumed, want 0", qword.size());
    end
    vectors++;
    if (qstat.size() != 0) begin
      miscompares++;
      $display("FAIL status_drain: got %0d unchecked cycles, want 0", qstat.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
